// File: rtl/sipo_deser_ctrl.sv
// Serial-in/parallel-out frame controller: MSB-first shift, bit counting, one-word output buffer.
// Optional even-parity bit per frame when SIPO_PARITY_EN is defined (adds parity_err output).
module sipo_deser_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         si,
    input  logic         si_valid,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         busy,
    output logic         overrun,
`ifdef SIPO_PARITY_EN
    output logic         parity_err,
`endif
    input  logic         clr_ovr
);

    typedef enum logic [1:0] {
        StIdle,
`ifdef SIPO_PARITY_EN
        StParity,
`endif
        StShift
    } state_e;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(N - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [N-1:0]       word_out_d;
    logic               word_valid_d;
    logic               overrun_d;
    logic               done;
    logic [N-1:0]       done_word;
    logic               drain, load, drop;
`ifdef SIPO_PARITY_EN
    logic               parity_err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                // A new start abandons the partial word without flagging it.
                if (start) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (si_valid) begin
                    shreg_d = {shreg_q[N-2:0], si};
                    if (cnt_q == LastBit) begin
`ifdef SIPO_PARITY_EN
                        state_d = StParity;
                        cnt_d   = cnt_q + CNT_W'(1);
`else
                        state_d = StIdle;
                        cnt_d   = '0;
                        done    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            StParity: begin
                if (start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (si_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done    = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef SIPO_PARITY_EN
    assign done_word = shreg_q;
`else
    assign done_word = shreg_d;
`endif

    // Output buffer accepts a new word when empty or emptying on this same edge.
    always_comb begin
        drain        = word_valid & word_ready;
        load         = done & (~word_valid | drain);
        drop         = done & ~load;
        word_out_d   = load ? done_word : word_out;
        word_valid_d = load ? 1'b1 : (drain ? 1'b0 : word_valid);
        overrun_d    = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun);
`ifdef SIPO_PARITY_EN
        parity_err_d = load ? (^shreg_q ^ si) : parity_err;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            word_out   <= word_out_d;
            word_valid <= word_valid_d;
            overrun    <= overrun_d;
`ifdef SIPO_PARITY_EN
            parity_err <= parity_err_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_sipo_deser_ctrl.sv
// Directed self-checking bench for sipo_deser_ctrl (N=8); parity tests enabled with SIPO_PARITY_EN.
module tb_sipo_deser_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         si = 1'b0;
    logic         si_valid = 1'b0;
    logic [N-1:0] word_out;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic         busy;
    logic         overrun;
    logic         clr_ovr = 1'b0;
`ifdef SIPO_PARITY_EN
    logic         parity_err;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int hs = 0;
    int hs_base;

    sipo_deser_ctrl #(.N(N), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .si         (si),
        .si_valid   (si_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun),
`ifdef SIPO_PARITY_EN
        .parity_err (parity_err),
`endif
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (word_valid && word_ready) hs++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        si = b;
        si_valid = 1'b1;
        tick();
        si_valid = 1'b0;
        si = 1'b0;
    endtask

    // Sends N data bits MSB first; with parity, appends even parity optionally inverted.
    task automatic send_frame(input logic [N-1:0] w, input int gap, input logic flip);
        for (int i = N - 1; i >= 0; i--) send_bit(w[i], gap);
`ifdef SIPO_PARITY_EN
        send_bit((^w) ^ flip, gap);
`else
        if (flip) $display("note: parity flip ignored without parity build");
`endif
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_eq("rst_valid", word_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_word", word_out, 0);
`ifdef SIPO_PARITY_EN
        check_eq("rst_perr", parity_err, 0);
`endif

        // 1: basic frame
        do_start();
        check_eq("t1_busy", busy, 1);
        check_eq("t1_valid_pre", word_valid, 0);
        send_frame(8'hB2, 0, 1'b0);
        check_eq("t1_word", word_out, 32'hB2);
        check_eq("t1_valid", word_valid, 1);
        check_eq("t1_busy_done", busy, 0);
`ifdef SIPO_PARITY_EN
        check_eq("t1_perr", parity_err, 0);
`endif
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check_eq("t1_drained", word_valid, 0);

        // 2: overrun on back-pressure
        do_start();
        send_frame(8'hB2, 0, 1'b0);
        do_start();
        send_frame(8'h5A, 0, 1'b0);
        check_eq("t2_word_held", word_out, 32'hB2);
        check_eq("t2_valid", word_valid, 1);
        check_eq("t2_ovr", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_eq("t2_ovr_clr", overrun, 0);
        check_eq("t2_valid_kept", word_valid, 1);
        word_ready = 1'b1;
        tick();
        check_eq("t2_drained", word_valid, 0);

        // 3: back-to-back with ready held
        hs_base = hs;
        do_start();
        send_frame(8'h01, 0, 1'b0);
        check_eq("t3_word1", word_out, 32'h01);
        check_eq("t3_valid1", word_valid, 1);
        do_start();
        check_eq("t3_drain1", word_valid, 0);
        send_frame(8'h80, 0, 1'b0);
        check_eq("t3_word2", word_out, 32'h80);
        check_eq("t3_valid2", word_valid, 1);
        tick();
        check_eq("t3_drain2", word_valid, 0);
        check_eq("t3_hs", hs - hs_base, 2);
        check_eq("t3_ovr", overrun, 0);
        word_ready = 1'b0;

        // 4: abort and restart
        hs_base = hs;
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        do_start();
        check_eq("t4_busy", busy, 1);
        check_eq("t4_valid_pre", word_valid, 0);
        send_frame(8'hC3, 0, 1'b0);
        check_eq("t4_word", word_out, 32'hC3);
        check_eq("t4_valid", word_valid, 1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        repeat (3) tick();
        check_eq("t4_one_word", hs - hs_base, 1);
        check_eq("t4_valid_after", word_valid, 0);
        check_eq("t4_ovr", overrun, 0);

        // 5: gapped bits, then async reset mid-frame
        do_start();
        send_frame(8'hA5, 2, 1'b0);
        check_eq("t5_word", word_out, 32'hA5);
        check_eq("t5_valid", word_valid, 1);
        do_start();
        send_frame(8'h3C, 0, 1'b0);
        check_eq("t5_ovr", overrun, 1);
        check_eq("t5_word_held", word_out, 32'hA5);
        do_start();
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        check_eq("t5_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_valid", word_valid, 0);
        check_eq("t5_rst_word", word_out, 0);
        check_eq("t5_rst_ovr", overrun, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("t5_idle", busy, 0);

`ifdef SIPO_PARITY_EN
        // 6: parity good then bad
        do_start();
        send_frame(8'hB2, 0, 1'b0);
        check_eq("t6_word", word_out, 32'hB2);
        check_eq("t6_perr0", parity_err, 0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        do_start();
        send_frame(8'hB2, 0, 1'b1);
        check_eq("t6_perr1", parity_err, 1);
        check_eq("t6_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
